// File: rtl/krnl_partialknn_local_buf_pkg.sv
// Shared types and sizing for the partialKnn local search-space buffer controller.
package krnl_partialknn_local_buf_pkg;
  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 11;
  localparam int DEPTH      = 2048;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/krnl_partialknn_local_buf_ofifo.sv
// Shift-register output FIFO; entry 0 is the head, so the head word comes straight from a flop.
module krnl_partialknn_local_buf_ofifo #(
  parameter int DataWidth = 256,
  parameter int Depth     = 2,
  localparam int CntW     = $clog2(Depth + 1)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 pop,
  output logic [DataWidth-1:0] head,
  output logic [CntW-1:0]      count
);
  logic [Depth-1:0][DataWidth-1:0] entries;
  logic                            pop_ok, push_ok;
  logic [CntW-1:0]                 wr_idx;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CntW'(Depth)) || pop_ok);
  assign wr_idx  = pop_ok ? count - CntW'(1) : count;
  assign head    = entries[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      entries <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (pop_ok && i < Depth - 1) entries[i] <= entries[i+1];
        if (push_ok && wr_idx == CntW'(i)) entries[i] <= push_data;
      end
      count <= count + CntW'(push_ok) - CntW'(pop_ok);
    end
  end
endmodule

// File: rtl/krnl_partialknn_local_buf_ctrl.sv
// Fill/drain controller for one partialKnn URAM local buffer: stream in a burst, then
// replay it in address order through a credit-limited read pipeline.
module krnl_partialknn_local_buf_ctrl
  import krnl_partialknn_local_buf_pkg::*;
#(
  parameter int DataWidth    = DATA_W,
  parameter int AddressRange = DEPTH,
  parameter int AddressWidth = ADDR_W,
  parameter int ReadLatency  = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    start,
  input  logic [AddressWidth:0]   num_words,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
);
  localparam int FifoDepth = ReadLatency + 1;
  localparam int CntW      = $clog2(FifoDepth + 1);
  localparam int PtrW      = AddressWidth + 1;
  localparam logic [PtrW-1:0] RANGE = PtrW'(AddressRange);

  state_e                 state;
  logic [PtrW-1:0]        num_q, wr_ptr, rd_ptr, out_cnt;
  logic [CntW-1:0]        inflight, fifo_count;
  logic [CntW:0]          credits_used;
  logic [ReadLatency-1:0] vld_pipe;
  logic                   fill_hs, rd_issue, q_push, out_hs;

  assign in_ready  = (state == ST_FILL);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign fill_hs   = in_ready && in_valid;
  assign out_valid = (fifo_count != '0);
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && (out_cnt == num_q - PtrW'(1));
  assign q_push    = vld_pipe[ReadLatency-1];

  // A pop in this cycle returns its credit at once, so drain keeps one word per cycle.
  assign credits_used = {1'b0, fifo_count} + {1'b0, inflight} - (CntW+1)'(out_hs);
  assign rd_issue     = (state == ST_DRAIN) && (rd_ptr < num_q) &&
                        (credits_used < (CntW+1)'(FifoDepth));

  always_comb begin
    mem_ce0      = fill_hs || rd_issue;
    mem_we0      = fill_hs;
    mem_address0 = '0;
    mem_d0       = '0;
    if (fill_hs) begin
      mem_address0 = wr_ptr[AddressWidth-1:0];
      mem_d0       = in_data;
    end else if (rd_issue) begin
      mem_address0 = rd_ptr[AddressWidth-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= ST_IDLE;
      num_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          if (num_words == '0) begin
            state <= ST_DONE;
          end else begin
            num_q   <= (num_words > RANGE) ? RANGE : num_words;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_cnt <= '0;
            state   <= ST_FILL;
          end
        end
        ST_FILL: if (fill_hs) begin
          wr_ptr <= wr_ptr + PtrW'(1);
          if (wr_ptr + PtrW'(1) == num_q) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (rd_issue) rd_ptr <= rd_ptr + PtrW'(1);
          if (out_hs) begin
            out_cnt <= out_cnt + PtrW'(1);
            if (out_last) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // vld_pipe tracks each issued read until its data sits on mem_q0.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | ReadLatency'(rd_issue);
      inflight <= inflight + CntW'(rd_issue) - CntW'(q_push);
    end
  end

  krnl_partialknn_local_buf_ofifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) u_ofifo (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .push      (q_push),
    .push_data (mem_q0),
    .pop       (out_hs),
    .head      (out_data),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_krnl_partialknn_local_buf_ctrl.sv
// Directed bench for the local buffer controller with a behavioural URAM of latency RL.
module tb_krnl_partialknn_local_buf_ctrl;
  localparam int RL = 2;
  localparam int W  = 256;
  localparam int AW = 11;

  logic          ap_clk = 1'b0, ap_rst_n = 1'b0, start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0, mem_we0;
  logic [W-1:0]  mem_d0, mem_q0;
  int            total = 0, bad = 0;

  always #5 ap_clk = ~ap_clk;

  krnl_partialknn_local_buf_ctrl #(.ReadLatency(RL)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .mem_address0(mem_address0), .mem_ce0(mem_ce0),
    .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  // URAM model: read data appears RL cycles after the ce0 cycle.
  logic [W-1:0] uram [0:2047];
  logic [W-1:0] q_pipe [0:RL-1];
  always @(posedge ap_clk) begin
    if (mem_ce0 && mem_we0) uram[mem_address0] <= mem_d0;
    q_pipe[0] <= (mem_ce0 && !mem_we0) ? uram[mem_address0] : '0;
    for (int k = 1; k < RL; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign mem_q0 = q_pipe[RL-1];

  int            cyc = 0, n_rd = 0, outst = 0, max_outst = 0, stab_err = 0, n_done = 0, n_busy = 0;
  int            last_wr_cyc = 0, first_vld_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [W-1:0]  wr_data_q[$], out_q[$];
  logic          last_q[$];
  logic          prev_stall = 1'b0, prev_vld = 1'b0;
  logic [W-1:0]  prev_data = '0;

  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      outst = 0; prev_stall = 1'b0; prev_vld = 1'b0;
    end else begin
      if (mem_ce0 && mem_we0) begin
        wr_addr_q.push_back(mem_address0); wr_data_q.push_back(mem_d0); last_wr_cyc = cyc;
      end
      if (mem_ce0 && !mem_we0) begin n_rd++; outst++; end
      if (prev_stall && !(out_valid && out_data === prev_data)) stab_err++;
      if (out_valid && !prev_vld) first_vld_cyc = cyc;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data); last_q.push_back(out_last); outst--;
        if (out_last) last_hs_cyc = cyc;
      end
      if (outst > max_outst) max_outst = outst;
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy++;
      prev_stall = out_valid && !out_ready; prev_vld = out_valid; prev_data = out_data;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_in_ready"}, W'(in_ready), W'(0));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_out_last"}, W'(out_last), W'(0));
    check({tag, "_out_data"}, out_data, W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
    check({tag, "_ce0"}, W'(mem_ce0), W'(0));
    check({tag, "_we0"}, W'(mem_we0), W'(0));
    check({tag, "_addr0"}, W'(mem_address0), W'(0));
    check({tag, "_d0"}, mem_d0, W'(0));
  endtask

  task automatic start_pass(input int n);
    start = 1'b1; num_words = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic fill(input int n, input bit bub, input logic [W-1:0] base);
    int  i = 0, guard = 0;
    bit  hs;
    while (i < n && guard < 10000) begin
      in_valid = bub ? guard[0] : 1'b1;
      in_data  = base + W'(i);
      @(negedge ap_clk); hs = in_valid && in_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0; in_data = '0;
    check("fill_count", W'(i), W'(n));
  endtask

  task automatic wait_done(input int pct);
    int g = 0;
    bit seen = 1'b0;
    while (!seen && g < 20000) begin
      out_ready = ($urandom_range(0, 99) < pct);
      @(negedge ap_clk); seen = done;
      tick();
      g++;
    end
    out_ready = 1'b0;
    check("done_seen", W'(seen), W'(1));
    check("idle_after_done", W'(busy), W'(0));
  endtask

  initial begin
    int wb, ob, nd, nb, rr, e;
    repeat (2) tick();
    check_rst("rst");
    ap_rst_n = 1'b1;
    tick();

    // Basic pass
    wb = wr_addr_q.size(); ob = out_q.size(); nd = n_done;
    start_pass(4);
    check("basic_in_ready", W'(in_ready), W'(1));
    check("basic_busy", W'(busy), W'(1));
    fill(4, 1'b0, W'(256'hA0));
    check("basic_drain_in_ready", W'(in_ready), W'(0));
    wait_done(100);
    check("basic_nwr", W'(wr_addr_q.size() - wb), W'(4));
    check("basic_nout", W'(out_q.size() - ob), W'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_waddr%0d", i), W'(wr_addr_q[wb+i]), W'(i));
      check($sformatf("basic_wdata%0d", i), wr_data_q[wb+i], W'(256'hA0) + W'(i));
      check($sformatf("basic_out%0d", i), out_q[ob+i], W'(256'hA0) + W'(i));
      check($sformatf("basic_last%0d", i), W'(last_q[ob+i]), W'(i == 3));
    end
    check("basic_first_latency", W'(first_vld_cyc - last_wr_cyc), W'(RL + 2));
    check("basic_done_latency", W'(done_cyc - last_hs_cyc), W'(1));
    check("basic_done_pulses", W'(n_done - nd), W'(1));

    // Zero length
    nb = n_busy; nd = n_done; rr = n_rd; wb = wr_addr_q.size();
    start_pass(0);
    check("zero_done_c1", W'(done), W'(1));
    check("zero_busy_c1", W'(busy), W'(1));
    tick();
    check("zero_done_c2", W'(done), W'(0));
    check("zero_busy_c2", W'(busy), W'(0));
    check("zero_busy_cycles", W'(n_busy - nb), W'(1));
    check("zero_done_pulses", W'(n_done - nd), W'(1));
    check("zero_no_reads", W'(n_rd - rr), W'(0));
    check("zero_no_writes", W'(wr_addr_q.size() - wb), W'(0));

    // start held high during FILL must not relatch num_words
    ob = out_q.size();
    start_pass(3);
    start = 1'b1; num_words = 12'd5;
    fill(3, 1'b0, W'(256'h10));
    start = 1'b0;
    check("swb_in_ready", W'(in_ready), W'(0));
    wait_done(100);
    check("swb_nout", W'(out_q.size() - ob), W'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("swb_out%0d", i), out_q[ob+i], W'(256'h10) + W'(i));
    check("swb_last", W'(last_q[ob+2]), W'(1));

    // Backpressure
    ob = out_q.size(); e = 0;
    start_pass(16);
    fill(16, 1'b0, W'(256'h1000));
    wait_done(30);
    check("bp_nout", W'(out_q.size() - ob), W'(16));
    for (int i = 0; i < 16; i++) begin
      if (out_q[ob+i] !== W'(256'h1000) + W'(i)) e++;
      if (last_q[ob+i] !== (i == 15)) e++;
    end
    check("bp_data_errs", W'(e), W'(0));
    check("bp_max_outstanding_ok", W'(max_outst <= RL + 1), W'(1));
    check("bp_stall_stable_errs", W'(stab_err), W'(0));

    // Full depth with input bubbles
    wb = wr_addr_q.size(); ob = out_q.size(); e = 0;
    start_pass(2048);
    fill(2048, 1'b1, W'(256'h20000));
    wait_done(100);
    check("full_nwr", W'(wr_addr_q.size() - wb), W'(2048));
    check("full_nout", W'(out_q.size() - ob), W'(2048));
    for (int i = 0; i < 2048; i++) begin
      if (wr_addr_q[wb+i] !== AW'(i)) e++;
      if (out_q[ob+i] !== W'(256'h20000) + W'(i)) e++;
    end
    check("full_errs", W'(e), W'(0));
    check("full_last_addr", W'(wr_addr_q[wb+2047]), W'(2047));
    check("full_last_flag", W'(last_q[ob+2047]), W'(1));

    // Oversized request clamps to the buffer depth
    ob = out_q.size();
    start_pass(4095);
    fill(2048, 1'b0, W'(256'h30000));
    check("clamp_in_ready", W'(in_ready), W'(0));
    wait_done(100);
    check("clamp_nout", W'(out_q.size() - ob), W'(2048));
    check("clamp_last_data", out_q[ob+2047], W'(256'h30000) + W'(2047));

    // Reset mid-DRAIN with reads in flight, then a short clean pass
    start_pass(8);
    fill(8, 1'b0, W'(256'h40000));
    tick();
    @(negedge ap_clk); ap_rst_n = 1'b0;
    #1;
    check_rst("midrst");
    repeat (3) tick();
    ap_rst_n = 1'b1;
    tick();
    ob = out_q.size();
    start_pass(2);
    fill(2, 1'b0, W'(256'h55));
    wait_done(100);
    repeat (6) tick();
    check("post_rst_nout", W'(out_q.size() - ob), W'(2));
    check("post_rst_out0", out_q[ob], W'(256'h55));
    check("post_rst_out1", out_q[ob+1], W'(256'h56));
    check("post_rst_last", W'(last_q[ob+1]), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
